// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory and its address checker.
//   state_t          : sequencer state (clear after reset, then run)
//   PC_MODE_WORD/BYTE: how the fetch pc is interpreted
//   NOP_WORD_DEFAULT : word returned on faulted fetches and written by clear
package instr_mem_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  localparam int PC_MODE_WORD = 0;
  localparam int PC_MODE_BYTE = 1;

  // Zero today; may become addi x0,x0,0 (32'h00000013) later.
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_addr_chk.sv
// Combinational fetch-address translation and fault detection.
//   pc    : 64-bit fetch address (word index or byte address per PC_MODE)
//   idx   : word index into the array (only meaningful when fault=0)
//   fault : index beyond DEPTH (full-width compare) or misaligned byte address
module instr_mem_addr_chk
  import instr_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int AW      = $clog2(DEPTH),
  parameter int PC_MODE = PC_MODE_WORD
) (
  input  logic [63:0]   pc,
  output logic [AW-1:0] idx,
  output logic          fault
);

  logic [63:0] word;
  logic        misaligned;

  always_comb begin
    if (PC_MODE == PC_MODE_BYTE) begin
      word       = pc >> 2;
      misaligned = (pc[1:0] != 2'b00);
    end else begin
      word       = pc;
      misaligned = 1'b0;
    end
    idx   = word[AW-1:0];
    // Compare all 64 bits so a huge pc never aliases onto a valid word.
    fault = misaligned || (word >= 64'(DEPTH));
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with power-up clear and a program
// load port.
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   fetch_req, pc          : fetch request and address (PC_MODE interpretation)
//   fetch_valid            : instrucao/fetch_err valid, one cycle after request
//   instrucao, fetch_err   : fetched word, fault flag (word = NOP_WORD on fault)
//   prog_we/addr/data      : program write port, honoured only once ready
//   ready                  : clear sequence finished
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int             IW       = 32,
  parameter int             DEPTH    = 64,
  parameter int             AW       = $clog2(DEPTH),
  parameter int             PC_MODE  = PC_MODE_WORD,
  parameter logic [IW-1:0]  NOP_WORD = IW'(NOP_WORD_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [63:0]   pc,
  output logic          fetch_valid,
  output logic [IW-1:0] instrucao,
  output logic          fetch_err,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  output logic          ready
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_q;
  logic          sel_nop;   // instrucao shows NOP_WORD instead of rd_q

  logic [AW-1:0] idx;
  logic          fault;

  instr_mem_addr_chk #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .PC_MODE (PC_MODE)
  ) u_addr_chk (
    .pc    (pc),
    .idx   (idx),
    .fault (fault)
  );

  logic          run;
  logic          fetch_go;
  logic          clr_we;
  logic          prog_ok;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] wdata;

  assign run      = (state == ST_RUN);
  assign fetch_go = run && fetch_req && !reset;
  assign clr_we   = (state == ST_CLEAR) && !reset;
  assign prog_ok  = run && prog_we && !reset && (32'(prog_addr) < 32'(DEPTH));

  // Single write port shared by the clear sequencer and the program port.
  assign we    = clr_we || prog_ok;
  assign waddr = clr_we ? cnt : prog_addr;
  assign wdata = clr_we ? NOP_WORD : prog_data;

  // Storage: no reset so it maps onto block RAM with a registered read.
  // Nonblocking read and write in one block give read-before-write.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (fetch_go)
      rd_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      sel_nop     <= 1'b1;
    end else begin
      fetch_valid <= fetch_go;
      // Output flags only change on an accepted fetch so they hold otherwise.
      if (fetch_go) begin
        fetch_err <= fault;
        sel_nop   <= fault;
      end
      if (state == ST_CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1))
          state <= ST_RUN;
      end
    end
  end

  assign instrucao = sel_nop ? NOP_WORD : rd_q;
  assign ready     = run;

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised, synchronous-read instruction memory that replaces the fixed 64-word combinational ROM in the single-cycle datapath.
- Adds a registered fetch with req/valid handshake.
- Adds a program-load write port for the test harness.
- Adds a power-up clear sequencer and word/byte PC addressing.
- Flags out-of-range and misaligned fetches instead of silently returning zero.
- Sits between the PC register and the instruction decoder.

Parameters:
IW, 32, instruction width in bits
DEPTH, 64, number of instruction words; power of two, minimum 4
AW, $clog2(DEPTH), index width (derived; do not override)
PC_MODE, 0, 0 = pc is a word index; 1 = pc is a byte address (index = pc >> 2)
NOP_WORD, 0, value driven on instrucao for faulted fetches and written during clear

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch request, sampled each clk
pc  in  64  fetch address, interpreted per PC_MODE
fetch_valid  out  1  instrucao/fetch_err valid this cycle
instrucao  out  IW  fetched instruction
fetch_err  out  1  fetch faulted (out of range or misaligned)
prog_we  in  1  program write enable
prog_addr  in  AW  program write word index
prog_data  in  IW  program write data
ready  out  1  clear finished; fetches and writes accepted

Behaviour:
- Clocking: single clock `clk`; reset is synchronous and active-high, sampled on the rising edge.
- Reset values of outputs: fetch_valid=0, instrucao=NOP_WORD, fetch_err=0, ready=0. The clear counter resets to 0 and the FSM enters CLEAR.
- FSM CLEAR:
  - Each cycle, writes NOP_WORD to mem[cnt] and increments cnt.
  - On the cycle cnt==DEPTH-1 is written, goes to RUN.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts; ready rises on the following edge.
- FSM RUN: ready=1. Leaves RUN only on reset.
- Reset mid-operation:
  - Any state, including mid-CLEAR, returns to CLEAR with cnt=0.
  - Memory contents are re-cleared.
  - An in-flight fetch is discarded: fetch_valid=0 on the next cycle.
- Fetch in RUN:
  - fetch_req=1 at edge N produces fetch_valid=1 at edge N+1, a fixed 1-cycle latency.
  - Back-to-back requests give one result per cycle.
  - With fetch_req=0, fetch_valid=0 next cycle and instrucao/fetch_err hold their last values.
- Fetch during CLEAR: the request is dropped, no valid is ever produced for it, and memory is untouched.
- Index computation:
  - PC_MODE 0: idx = pc.
  - PC_MODE 1: idx = pc >> 2, and misaligned = (pc[1:0] != 0).
- Fault:
  - The fetch faults if idx >= DEPTH (full 64-bit compare; no truncation aliasing) or if misaligned.
  - On a fault: instrucao=NOP_WORD, fetch_err=1, fetch_valid=1.
  - Otherwise instrucao=mem[idx] and fetch_err=0.
- Program write:
  - In RUN, prog_we=1 writes prog_data to mem[prog_addr] at the edge.
  - Writes in CLEAR are ignored.
  - prog_addr >= DEPTH (possible only when DEPTH is not a power of two; disallowed) is ignored.
- Simultaneous write and fetch to the same index: read-before-write; the fetch returns the old word and the new word is visible from the next fetch.
- Memory has no initial-block contents; all content comes from clear plus prog writes. Storage must infer block RAM with a registered read.

Decomposition:
- Shared package `instr_mem_pkg`:
  - FSM state typedef (ST_CLEAR, ST_RUN).
  - PC_MODE_WORD=0 and PC_MODE_BYTE=1 constants.
  - Default NOP_WORD constant (0; the team may later set it to addi x0,x0,0 = 32'h00000013).
- One sub-module, `instr_mem_addr_chk`: combinational pc -> {idx, fault} per PC_MODE. It is reused by the future data memory.
- Storage array, FSM and output registers live in the top.

Test Plan:
1. Reset, then idle -> ready=0 for exactly 64 cycles, ready=1 on cycle 65. Fetches of pc=0..63 all return 32'h0 with fetch_err=0.
2. RUN, PC_MODE 0: write mem[1]=32'h00702083 and mem[2]=32'h015380B3, then fetch_req with pc=1 then pc=2 back-to-back -> fetch_valid on the next two cycles with those words, in order.
3. Out of range: pc=64, then pc=64'h8000_0000_0000_0001 -> instrucao=NOP_WORD, fetch_err=1, fetch_valid=1. Then pc=63 -> fetch_err=0.
4. PC_MODE 1: write mem[3]=32'hDEADBEEF. pc=12 -> 32'hDEADBEEF, err=0; pc=13 -> NOP_WORD, err=1; pc=256 -> err=1.
5. Same-cycle write mem[5]=32'hA5A5A5A5 and fetch pc=5 (old value 0) -> returns 0. The next fetch of pc=5 returns 32'hA5A5A5A5.
6. Reset asserted mid-CLEAR (cycle 20), plus prog_we and fetch_req during CLEAR -> no fetch_valid, ready rises 64 cycles after reset deasserts, and mem[0] still reads 0.
